div_err_monitor: RTL and testbench
==================================

# div_err_monitor

Sequential error-metric stage placed directly downstream of the 16/8 array dividers (approximate and exact) in the delay-MAE evaluation flow. Each cycle it can accept one sample pairing an approximate divider result with the exact result for the same operands. It accumulates absolute quotient error, peak error, mismatch counts and divide-by-zero counts over a fixed power-of-two window. When the window completes, it holds the metrics behind a valid/ready handshake.

## Interface
- W, 8, quotient/remainder/divisor width (matches divider q, r, d)
- LOG2_WIN, 10, window length is 2^LOG2_WIN samples; must be ≥1
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort: flush pipeline and accumulators, restart window
- in_valid  input  1  sample present
- in_ready  output  1  sample accepted when in_valid && in_ready at rising edge
- d  input  W  divisor of the sample (zero-divisor detection only)
- q_apx, r_apx  input  W each  approximate divider quotient/remainder
- q_ex, r_ex  input  W each  exact divider quotient/remainder
- res_valid  output  1  window metrics valid and stable
- res_ready  input  1  consumer takes metrics
- sum_abs  output  W+LOG2_WIN  Σ|q_apx−q_ex| over window
- mae  output  W  sum_abs >> LOG2_WIN (truncating)
- max_err  output  W  largest |q_apx−q_ex| in window
- q_mis_cnt  output  LOG2_WIN+1  samples with q_apx≠q_ex
- r_mis_cnt  output  LOG2_WIN+1  samples with r_apx≠r_ex
- dz_cnt  output  LOG2_WIN+1  samples with d==0

## Operation
- FSM states ACCUM, DRAIN, HOLD; reset state ACCUM.
- in_ready = 1 only in ACCUM; 0 in DRAIN, HOLD and while rst is high.
- Stage 1 registers per accepted sample:
  - abs = |q_apx−q_ex| as an unsigned W-bit magnitude (compute in W+1 bits, take magnitude);
  - q_mis, r_mis, dz flags;
  - s1_valid.
- Zero-divisor samples (d==0): abs and both mismatch flags forced to 0; dz flag 1. The sample still counts toward the window.
- Stage 2, on s1_valid:
  - sum_abs += abs;
  - max_err = max(max_err, abs);
  - each counter increments by its flag.
- Widths are sized so no overflow is possible within one window; no saturation logic.
- Sample counter (LOG2_WIN+1 bits) increments on each acceptance.
- ACCUM→DRAIN on the acceptance that brings the count to 2^LOG2_WIN.
- DRAIN→HOLD after one cycle, once stage 2 has absorbed the last sample.
- HOLD: res_valid=1; all metric outputs frozen.
- On res_valid && res_ready: zero the accumulators, counters, sample count and s1_valid, then go to ACCUM.
- clear has highest priority in every state. It zeroes all accumulators, counters, the sample count and s1_valid, and puts the FSM in ACCUM. A sample presented in the same cycle as clear is dropped.
- Metric outputs show the live accumulator values in ACCUM/DRAIN. They are meaningful only while res_valid=1.

## Timing
- Reset (async, takes effect immediately):
  - state ACCUM;
  - all metric outputs 0, res_valid 0;
  - in_ready 0 while rst is high, 1 from the first cycle after release.
- Throughput: one sample per cycle in ACCUM.
- Latency: last sample accepted at edge k → DRAIN after edge k; res_valid high after edge k+1.
- The next window's first sample can be accepted at the edge after the res_ready handshake edge (in_ready rises in that cycle).
- res_valid stays high until taken; outputs do not change while res_ready=0.
- mae is a combinational shift of the registered sum_abs; no extra latency.
- Reset mid-window discards all partial state; there is no partial-result output.

## Test plan
- LOG2_WIN=2. Samples (q_apx,q_ex) = (10,7), (4,4), (0,5), (9,11), all with d=3 and r equal.
  - Expect sum_abs=10, mae=2, max_err=5, q_mis_cnt=3, r_mis_cnt=0, dz_cnt=0.
  - Expect res_valid one cycle after the 4th acceptance.
- Zero divisor: one of 4 samples has d=0 and (q_apx,q_ex)=(255,0).
  - Expect that sample to contribute 0 to sum_abs and max_err; dz_cnt=1; q_mis_cnt excludes it.
- Backpressure: hold res_ready=0 for 5 cycles in HOLD with in_valid=1.
  - Expect in_ready=0 and outputs stable throughout.
  - After the handshake, metrics read 0 and the next 4 samples form a fresh window.
- clear asserted after 2 accepted samples, with in_valid=1 in the same cycle.
  - Expect the sample to be dropped and counters 0.
  - Expect 4 further samples to be needed before res_valid.
- Extremes, W=8: all 4 samples (255,0).
  - Expect sum_abs=1020, mae=255, max_err=255, q_mis_cnt=4.
- rst pulsed mid-window and during HOLD.
  - Expect res_valid and all outputs 0 immediately; in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/div_err_monitor.sv
// Windowed error-metric stage for approximate vs exact divider results.
// Accumulates |q error|, peak error, mismatch and zero-divisor counts over 2^LOG2_WIN samples.
module div_err_monitor #(
  parameter int W        = 8,
  parameter int LOG2_WIN = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          d,
  input  logic [W-1:0]          q_apx,
  input  logic [W-1:0]          r_apx,
  input  logic [W-1:0]          q_ex,
  input  logic [W-1:0]          r_ex,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [W+LOG2_WIN-1:0] sum_abs,
  output logic [W-1:0]          mae,
  output logic [W-1:0]          max_err,
  output logic [LOG2_WIN:0]     q_mis_cnt,
  output logic [LOG2_WIN:0]     r_mis_cnt,
  output logic [LOG2_WIN:0]     dz_cnt
);

  typedef enum logic [1:0] {ACCUM = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_e;

  localparam logic [LOG2_WIN:0] WIN_LAST = {1'b0, {LOG2_WIN{1'b1}}};

  state_e                state_q, state_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [W-1:0]          s1_abs_q, s1_abs_d;
  logic                  s1_qmis_q, s1_qmis_d;
  logic                  s1_rmis_q, s1_rmis_d;
  logic                  s1_dz_q, s1_dz_d;
  logic [W+LOG2_WIN-1:0] sum_q, sum_d;
  logic [W-1:0]          max_q, max_d;
  logic [LOG2_WIN:0]     qmis_q, qmis_d;
  logic [LOG2_WIN:0]     rmis_q, rmis_d;
  logic [LOG2_WIN:0]     dz_q, dz_d;
  logic [LOG2_WIN:0]     cnt_q, cnt_d;

  logic                  accept_s;
  logic                  flush_s;
  logic                  dz_s;
  logic [W:0]            diff_s;
  logic [W-1:0]          abs_s;

  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept_s = in_valid && in_ready && !clear;
  assign flush_s  = clear || ((state_q == HOLD) && res_ready);

  // Magnitude of the quotient error; zero divisors contribute nothing to the error metrics
  always_comb begin
    dz_s   = (d == {W{1'b0}});
    diff_s = {1'b0, q_apx} - {1'b0, q_ex};
    abs_s  = diff_s[W] ? W'(-diff_s) : diff_s[W-1:0];
    if (dz_s) begin
      abs_s = {W{1'b0}};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept_s && (cnt_q == WIN_LAST)) state_d = DRAIN;
      DRAIN:   state_d = HOLD;
      HOLD:    if (res_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d = ACCUM;
    end
  end

  always_comb begin
    s1_valid_d = accept_s;
    s1_abs_d   = abs_s;
    s1_qmis_d  = !dz_s && (q_apx != q_ex);
    s1_rmis_d  = !dz_s && (r_apx != r_ex);
    s1_dz_d    = dz_s;
    sum_d      = sum_q;
    max_d      = max_q;
    qmis_d     = qmis_q;
    rmis_d     = rmis_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    if (s1_valid_q) begin
      sum_d  = sum_q + (W + LOG2_WIN)'(s1_abs_q);
      max_d  = (s1_abs_q > max_q) ? s1_abs_q : max_q;
      qmis_d = qmis_q + (LOG2_WIN + 1)'(s1_qmis_q);
      rmis_d = rmis_q + (LOG2_WIN + 1)'(s1_rmis_q);
      dz_d   = dz_q + (LOG2_WIN + 1)'(s1_dz_q);
    end
    if (accept_s) begin
      cnt_d = cnt_q + {{LOG2_WIN{1'b0}}, 1'b1};
    end
    // Abort or result handoff restarts the window from a clean slate
    if (flush_s) begin
      s1_valid_d = 1'b0;
      sum_d      = {(W + LOG2_WIN){1'b0}};
      max_d      = {W{1'b0}};
      qmis_d     = {(LOG2_WIN + 1){1'b0}};
      rmis_d     = {(LOG2_WIN + 1){1'b0}};
      dz_d       = {(LOG2_WIN + 1){1'b0}};
      cnt_d      = {(LOG2_WIN + 1){1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      s1_valid_q <= 1'b0;
      s1_abs_q   <= {W{1'b0}};
      s1_qmis_q  <= 1'b0;
      s1_rmis_q  <= 1'b0;
      s1_dz_q    <= 1'b0;
      sum_q      <= {(W + LOG2_WIN){1'b0}};
      max_q      <= {W{1'b0}};
      qmis_q     <= {(LOG2_WIN + 1){1'b0}};
      rmis_q     <= {(LOG2_WIN + 1){1'b0}};
      dz_q       <= {(LOG2_WIN + 1){1'b0}};
      cnt_q      <= {(LOG2_WIN + 1){1'b0}};
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_abs_q   <= s1_abs_d;
      s1_qmis_q  <= s1_qmis_d;
      s1_rmis_q  <= s1_rmis_d;
      s1_dz_q    <= s1_dz_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      qmis_q     <= qmis_d;
      rmis_q     <= rmis_d;
      dz_q       <= dz_d;
      cnt_q      <= cnt_d;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign sum_abs   = sum_q;
  assign mae       = W'(sum_q >> LOG2_WIN);
  assign max_err   = max_q;
  assign q_mis_cnt = qmis_q;
  assign r_mis_cnt = rmis_q;
  assign dz_cnt    = dz_q;

endmodule

// File: tb/tb_div_err_monitor.sv
// Directed + randomized bench for div_err_monitor with a sample-queue reference model.
module tb_div_err_monitor;
  localparam int W  = 8;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  d = '0, q_apx = '0, r_apx = '0, q_ex = '0, r_ex = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W+LW-1:0] sum_abs;
  logic [W-1:0]  mae, max_err;
  logic [LW:0]   q_mis_cnt, r_mis_cnt, dz_cnt;

  int n_cmp = 0;
  int n_mis = 0;
  int qa_q[$], qe_q[$], ra_q[$], re_q[$], d_q[$];

  div_err_monitor #(.W(W), .LOG2_WIN(LW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .d(d), .q_apx(q_apx), .r_apx(r_apx), .q_ex(q_ex), .r_ex(r_ex),
    .res_valid(res_valid), .res_ready(res_ready), .sum_abs(sum_abs), .mae(mae),
    .max_err(max_err), .q_mis_cnt(q_mis_cnt), .r_mis_cnt(r_mis_cnt), .dz_cnt(dz_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa_q.delete(); qe_q.delete(); ra_q.delete(); re_q.delete(); d_q.delete();
  endtask

  // Presents one sample for one cycle; called just after a falling edge
  task automatic push(input int qa, input int qe, input int ra, input int re, input int dd);
    q_apx = W'(qa); q_ex = W'(qe); r_apx = W'(ra); r_ex = W'(re); d = W'(dd);
    in_valid = 1'b1;
    chk("push_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    qa_q.push_back(qa); qe_q.push_back(qe); ra_q.push_back(ra); re_q.push_back(re); d_q.push_back(dd);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_rand();
    int qa, qe, ra, re;
    qa = int'($urandom_range(0, 255));
    qe = ($urandom_range(0, 1) == 0) ? qa : int'($urandom_range(0, 255));
    ra = int'($urandom_range(0, 255));
    re = ($urandom_range(0, 1) == 0) ? ra : int'($urandom_range(0, 255));
    push(qa, qe, ra, re, int'($urandom_range(0, 7)));
  endtask

  // Called right after the last push: one cycle of DRAIN, then metrics compared to the model
  task automatic check_window();
    int e_sum, e_max, e_qm, e_rm, e_dz, a;
    e_sum = 0; e_max = 0; e_qm = 0; e_rm = 0; e_dz = 0;
    foreach (qa_q[i]) begin
      if (d_q[i] == 0) begin
        e_dz++;
      end else begin
        a = (qa_q[i] > qe_q[i]) ? qa_q[i] - qe_q[i] : qe_q[i] - qa_q[i];
        e_sum += a;
        if (a > e_max) e_max = a;
        if (qa_q[i] != qe_q[i]) e_qm++;
        if (ra_q[i] != re_q[i]) e_rm++;
      end
    end
    chk("drain_res_valid", 32'(res_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("sum_abs", 32'(sum_abs), 32'(e_sum));
    chk("mae", 32'(mae), 32'(e_sum / (1 << LW)));
    chk("max_err", 32'(max_err), 32'(e_max));
    chk("q_mis_cnt", 32'(q_mis_cnt), 32'(e_qm));
    chk("r_mis_cnt", 32'(r_mis_cnt), 32'(e_rm));
    chk("dz_cnt", 32'(dz_cnt), 32'(e_dz));
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post_hs_res_valid", 32'(res_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_sum_abs", 32'(sum_abs), 32'd0);
    chk("post_hs_max_err", 32'(max_err), 32'd0);
    chk("post_hs_q_mis", 32'(q_mis_cnt), 32'd0);
    model_reset();
  endtask

  task automatic check_zeroed(input string tag, input logic exp_ready);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
    chk({tag, "_sum_abs"}, 32'(sum_abs), 32'd0);
    chk({tag, "_max_err"}, 32'(max_err), 32'd0);
    chk({tag, "_q_mis"}, 32'(q_mis_cnt), 32'd0);
    chk({tag, "_dz"}, 32'(dz_cnt), 32'd0);
  endtask

  initial begin
    logic [W+LW-1:0] held_sum;
    logic [W-1:0]    held_max;
    #2;
    check_zeroed("in_reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Directed window from the plan
    push(10, 7, 1, 1, 3); push(4, 4, 2, 2, 3); push(0, 5, 0, 0, 3); push(9, 11, 1, 1, 3);
    check_window();
    chk("dir_sum_const", 32'(sum_abs), 32'd10);
    chk("dir_mae_const", 32'(mae), 32'd2);
    chk("dir_max_const", 32'(max_err), 32'd5);
    handshake();

    // Zero divisor masks a large error
    push(1, 2, 0, 0, 3); push(255, 0, 4, 9, 0); push(3, 3, 1, 1, 5); push(7, 1, 2, 3, 1);
    check_window();
    chk("dz_max_const", 32'(max_err), 32'd6);
    handshake();

    // Backpressure in HOLD with a sample waiting
    repeat (4) push_rand();
    check_window();
    held_sum = sum_abs; held_max = max_err;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_sum_stable", 32'(sum_abs), 32'(held_sum));
      chk("bp_max_stable", 32'(max_err), 32'(held_max));
    end
    in_valid = 1'b0;
    handshake();
    repeat (4) push_rand();
    check_window();
    handshake();

    // Clear after two samples drops the concurrent sample
    push(50, 10, 1, 2, 3); push(20, 90, 1, 1, 3);
    q_apx = 8'd200; q_ex = 8'd0; d = 8'd3; in_valid = 1'b1; clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    check_zeroed("clear", 1'b1);
    push(1, 3, 0, 0, 2); push(6, 6, 0, 1, 2); push(0, 0, 0, 0, 0);
    chk("clear_not_done", 32'(res_valid), 32'd0);
    push(8, 2, 3, 3, 4);
    check_window();
    handshake();

    // Extremes
    repeat (4) push(255, 0, 0, 0, 1);
    check_window();
    chk("ext_sum_const", 32'(sum_abs), 32'd1020);
    chk("ext_mae_const", 32'(mae), 32'd255);
    handshake();

    // Random windows
    repeat (12) begin
      repeat (4) push_rand();
      check_window();
      handshake();
    end

    // Reset mid-window
    push(9, 1, 0, 1, 0); push(5, 200, 0, 0, 3);
    rst = 1'b1;
    #1;
    check_zeroed("rst_mid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_release_ready", 32'(in_ready), 32'd1);
    model_reset();
    repeat (4) push_rand();
    check_window();

    // Reset during HOLD
    rst = 1'b1;
    #1;
    check_zeroed("rst_hold", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_hold_release_ready", 32'(in_ready), 32'd1);
    model_reset();
    repeat (4) push_rand();
    check_window();
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
